// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multi-cycle MIPS subset core with one shared valid/ready memory port,
// a retired-instruction counter and a sticky fault/halt state.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] CRYPT_KEY = 32'hDEADB3EF,
    parameter int          RETIRE_W  = 32
) (
    input  logic                clk,
    input  logic                reset,
    output logic                mem_req,
    output logic                mem_we,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic                mem_ready,
    input  logic [31:0]         mem_rdata,
    output logic                halted,
    output logic [1:0]          fault,
    output logic [RETIRE_W-1:0] retired,
    output logic [31:0]         pc_debug,
    output logic [31:0]         instruction_debug,
    output logic [2:0]          state_debug
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd7
    } state_t;

    state_t state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [31:0] imm_q, imm_d, alu_q, alu_d, mdr_q, mdr_d;
    logic [RETIRE_W-1:0] ret_q, ret_d;
    logic [1:0] fault_q, fault_d;
    logic [31:0] rf_q [32];
    logic rf_we;
    logic [4:0] rf_waddr;
    logic [31:0] rf_wdata;

    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd;
    logic is_r, is_mem, legal, sel_and, sel_or, sel_sub, sel_slt, sel_xc;
    logic [31:0] imm_ext, opnd, alu_res;

    assign op      = ir_q[31:26];
    assign rs      = ir_q[25:21];
    assign rt      = ir_q[20:16];
    assign rd      = ir_q[15:11];
    assign funct   = ir_q[5:0];
    assign is_r    = op == 6'h00;
    assign is_mem  = op == 6'h23 || op == 6'h2B;
    assign legal   = is_r ? (funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F})
                          : (op inside {6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03});
    assign imm_ext = (op == 6'h0C || op == 6'h0D) ? {16'h0000, ir_q[15:0]} : {{16{ir_q[15]}}, ir_q[15:0]};
    // I-type ops reuse the R-type datapath with the latched immediate as second operand
    assign opnd    = is_r ? b_q : imm_q;
    assign sel_and = is_r ? funct == 6'h24 : op == 6'h0C;
    assign sel_or  = is_r ? funct == 6'h25 : op == 6'h0D;
    assign sel_sub = is_r && funct == 6'h22;
    assign sel_slt = is_r && funct == 6'h2A;
    assign sel_xc  = is_r && funct == 6'h3F;
    assign alu_res = sel_and ? a_q & opnd :
                     sel_or  ? a_q | opnd :
                     sel_sub ? a_q - opnd :
                     sel_slt ? {31'd0, $signed(a_q) < $signed(opnd)} :
                     sel_xc  ? (a_q + opnd) ^ CRYPT_KEY : a_q + opnd;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        imm_d    = imm_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        ret_d    = ret_q;
        fault_d  = fault_q;
        rf_we    = 1'b0;
        rf_waddr = rt;
        rf_wdata = alu_q;
        case (state_q)
            FETCH: if (mem_ready) begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + 32'd4;
                state_d = DECODE;
            end
            DECODE: begin
                a_d     = rf_q[rs];
                b_d     = rf_q[rt];
                imm_d   = imm_ext;
                fault_d = legal ? 2'b00 : 2'b01;
                state_d = legal ? EXEC : HALT;
            end
            EXEC: begin
                alu_d = alu_res;
                if (op == 6'h04 || op == 6'h02 || op == 6'h03) begin
                    pc_d     = op == 6'h04 ? (a_q == b_q ? pc_q + {imm_q[29:0], 2'b00} : pc_q)
                                           : {pc_q[31:28], ir_q[25:0], 2'b00};
                    rf_we    = op == 6'h03;
                    rf_waddr = 5'd31;
                    rf_wdata = pc_q;
                    ret_d    = ret_q + 1'b1;
                    state_d  = FETCH;
                end else if (is_mem) begin
                    fault_d = alu_res[1:0] != 2'b00 ? 2'b10 : 2'b00;
                    state_d = alu_res[1:0] != 2'b00 ? HALT : MEM;
                end else
                    state_d = WB;
            end
            MEM: if (mem_ready) begin
                mdr_d   = mem_rdata;
                ret_d   = op == 6'h2B ? ret_q + 1'b1 : ret_q;
                state_d = op == 6'h2B ? FETCH : WB;
            end
            WB: begin
                rf_we    = 1'b1;
                rf_waddr = is_r ? rd : rt;
                rf_wdata = op == 6'h23 ? mdr_q : alu_q;
                ret_d    = ret_q + 1'b1;
                state_d  = FETCH;
            end
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            ret_q   <= '0;
            fault_q <= 2'b00;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            ret_q   <= ret_d;
            fault_q <= fault_d;
            if (rf_we && rf_waddr != 5'd0) rf_q[rf_waddr] <= rf_wdata;
        end
    end

    assign mem_req           = !reset && (state_q == FETCH || state_q == MEM);
    assign mem_we            = state_q == MEM && op == 6'h2B;
    assign mem_addr          = state_q == MEM ? alu_q : pc_q;
    assign mem_wdata         = b_q;
    assign halted            = state_q == HALT;
    assign fault             = fault_q;
    assign retired           = ret_q;
    assign pc_debug          = pc_q;
    assign instruction_debug = ir_q;
    assign state_debug       = state_q;
endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: directed and random programs run on a wait-state memory model,
// register results observed through sw traffic and compared with an ISA-level model.
module tb_mips_multicycle_core;
    localparam logic [31:0] KEY = 32'hDEADB3EF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mem_req, mem_we, halted;
    logic [31:0] mem_addr, mem_wdata, pc_debug, instruction_debug;
    logic mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [1:0] fault;
    logic [31:0] retired;
    logic [2:0] state_debug;

    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] mem [256];
    logic [31:0] rm [32];
    int wait_n = 0;
    int wcnt = 0;
    int we_cycles = 0;
    bit prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];

    always #5 clk = ~clk;

    mips_multicycle_core dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .halted(halted),
        .fault(fault), .retired(retired), .pc_debug(pc_debug),
        .instruction_debug(instruction_debug), .state_debug(state_debug)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory with wait_n wait states per request; ready pulses at random while idle.
    always @(negedge clk) begin
        #1;
        if (mem_req) begin
            if (prev_wait) check("addr_stable", mem_addr, prev_addr);
            if (mem_we) we_cycles++;
            if (wcnt < wait_n) begin
                wcnt++;
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                prev_wait = 1'b1;
                prev_addr = mem_addr;
            end else begin
                wcnt = 0;
                mem_ready = 1'b1;
                prev_wait = 1'b0;
                mem_rdata = mem[mem_addr[9:2]];
                if (mem_we) begin
                    mem[mem_addr[9:2]] = mem_wdata;
                    wr_addr_q.push_back(mem_addr);
                    wr_data_q.push_back(mem_wdata);
                end
            end
        end else begin
            wcnt = 0;
            prev_wait = 1'b0;
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
        end
    end

    function automatic logic [31:0] r_ins(int rs, int rt, int rd, logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] i_ins(logic [5:0] op, int rs, int rt, logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic void model_exec(logic [31:0] ins);
        logic [31:0] a, b, se, ze, v;
        int dst;
        a = rm[ins[25:21]];
        b = rm[ins[20:16]];
        se = {{16{ins[15]}}, ins[15:0]};
        ze = {16'h0000, ins[15:0]};
        dst = int'(ins[20:16]);
        case (ins[31:26])
            6'h00: begin
                dst = int'(ins[15:11]);
                case (ins[5:0])
                    6'h20: v = a + b;
                    6'h22: v = a - b;
                    6'h24: v = a & b;
                    6'h25: v = a | b;
                    6'h2A: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: v = (a + b) ^ KEY;
                endcase
            end
            6'h08: v = a + se;
            6'h0C: v = a & ze;
            default: v = a | ze;
        endcase
        if (dst != 0) rm[dst] = v;
    endfunction

    task automatic hold_reset(input int w);
        @(negedge clk);
        reset = 1'b1;
        wait_n = w;
        we_cycles = 0;
        wr_addr_q.delete();
        wr_data_q.delete();
        for (int i = 0; i < 256; i++) mem[i] = '0;
        @(negedge clk);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_write(input string tag, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        while (wr_addr_q.size() == 0 && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        check({tag, "_seen"}, 32'(wr_addr_q.size() != 0), 32'd1);
        if (wr_addr_q.size() != 0) begin
            check({tag, "_addr"}, wr_addr_q.pop_front(), a);
            check({tag, "_data"}, wr_data_q.pop_front(), d);
        end
    endtask

    task automatic load_prog_a();
        mem[0] = i_ins(6'h08, 0, 1, 16'd5);
        mem[1] = i_ins(6'h08, 0, 2, 16'hFFFD);
        mem[2] = r_ins(1, 2, 3, 6'h20);
        mem[3] = i_ins(6'h2B, 0, 3, 16'h0100);
        mem[4] = i_ins(6'h04, 0, 0, 16'hFFFF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state and zero-wait ALU program
        hold_reset(0);
        load_prog_a();
        check("rst_pc", pc_debug, 32'h0);
        check("rst_ir", instruction_debug, 32'h0);
        check("rst_state", 32'(state_debug), 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        reset = 1'b0;
        cycles(12);
        check("alu_retired", retired, 32'd3);
        check("alu_pc", pc_debug, 32'd12);
        expect_write("alu_add", 32'h100, 32'd2);

        // lw with three wait states per request; halts on the data word that follows
        hold_reset(3);
        mem[0] = i_ins(6'h23, 0, 4, 16'd8);
        mem[1] = i_ins(6'h2B, 0, 4, 16'h0104);
        mem[2] = 32'hCAFEF00D;
        reset = 1'b0;
        cycles(7);
        check("lw_mem_req", 32'(mem_req), 32'd1);
        check("lw_mem_we", 32'(mem_we), 32'd0);
        check("lw_mem_addr", mem_addr, 32'd8);
        cycles(4);
        check("lw_retired", retired, 32'd1);
        expect_write("lw_val", 32'h104, 32'hCAFEF00D);
        cycles(8);
        check("lw_tail_halted", 32'(halted), 32'd1);
        check("lw_tail_fault", 32'(fault), 32'd1);

        // sw produces exactly one write cycle
        hold_reset(0);
        mem[0] = i_ins(6'h08, 0, 1, 16'd5);
        mem[1] = i_ins(6'h2B, 0, 1, 16'd16);
        mem[2] = i_ins(6'h04, 0, 0, 16'hFFFF);
        reset = 1'b0;
        cycles(20);
        check("sw_we_cycles", 32'(we_cycles), 32'd1);
        expect_write("sw", 32'd16, 32'd5);

        // xcrypt then a beq self-loop
        hold_reset(0);
        mem[0] = i_ins(6'h08, 0, 1, 16'd1);
        mem[1] = r_ins(1, 2, 5, 6'h3F);
        mem[2] = i_ins(6'h2B, 0, 5, 16'h0108);
        mem[3] = i_ins(6'h04, 0, 0, 16'hFFFF);
        reset = 1'b0;
        cycles(12);
        check("xc_retired", retired, 32'd3);
        check("xc_pc", pc_debug, 32'd12);
        for (int k = 1; k <= 3; k++) begin
            cycles(3);
            check("beq_retired", retired, 32'(3 + k));
            check("beq_pc", pc_debug, 32'd12);
        end
        expect_write("xcrypt", 32'h108, 32'hDEADB3EE);

        // jal, $0 write discard, then illegal opcode halt
        hold_reset(0);
        mem[0] = i_ins(6'h08, 0, 0, 16'd7);
        mem[1] = i_ins(6'h08, 0, 0, 16'd7);
        mem[2] = {6'h03, 26'h40};
        mem[8'h40] = i_ins(6'h2B, 0, 31, 16'h0300);
        mem[8'h41] = i_ins(6'h2B, 0, 0, 16'h0304);
        mem[8'h42] = 32'hFC000000;
        reset = 1'b0;
        cycles(11);
        check("jal_pc", pc_debug, 32'h100);
        check("jal_retired", retired, 32'd3);
        expect_write("jal_ra", 32'h300, 32'd12);
        expect_write("r0_zero", 32'h304, 32'd0);
        cycles(12);
        check("ill_halted", 32'(halted), 32'd1);
        check("ill_fault", 32'(fault), 32'd1);
        check("ill_state", 32'(state_debug), 32'd7);
        check("ill_retired", retired, 32'd5);
        for (int k = 0; k < 5; k++) begin
            cycles(1);
            check("halt_mem_req", 32'(mem_req), 32'd0);
            check("halt_pc", pc_debug, 32'h10C);
        end

        // misaligned load
        hold_reset(0);
        mem[0] = i_ins(6'h23, 0, 1, 16'd2);
        reset = 1'b0;
        cycles(10);
        check("mis_halted", 32'(halted), 32'd1);
        check("mis_fault", 32'(fault), 32'd2);
        check("mis_retired", retired, 32'd0);

        // reset during a fetch wait state
        hold_reset(3);
        load_prog_a();
        reset = 1'b0;
        cycles(9);
        check("mid_retired", retired, 32'd1);
        check("mid_state", 32'(state_debug), 32'd0);
        reset = 1'b1;
        #2;
        check("mid_rst_req", 32'(mem_req), 32'd0);
        cycles(1);
        check("mid_rst_pc", pc_debug, 32'h0);
        check("mid_rst_retired", retired, 32'd0);
        check("mid_rst_state", 32'(state_debug), 32'd0);
        check("mid_rst_req2", 32'(mem_req), 32'd0);
        reset = 1'b0;
        cycles(21);
        check("mid_again_retired", retired, 32'd3);
        check("mid_again_pc", pc_debug, 32'd12);
        expect_write("mid_again", 32'h100, 32'd2);

        // random ALU programs against the ISA model
        for (int t = 0; t < 8; t++) begin
            int w, nk, k, rs, rt, rd;
            logic [31:0] ins;
            logic [5:0] fns [6];
            logic [5:0] iops [3];
            fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F};
            iops = '{6'h08, 6'h0C, 6'h0D};
            w = $urandom_range(0, 2);
            nk = 12;
            hold_reset(w);
            for (int i = 0; i < 32; i++) rm[i] = '0;
            for (int i = 0; i < nk; i++) begin
                k = $urandom_range(0, 8);
                rs = $urandom_range(0, 7);
                rt = $urandom_range(0, 7);
                rd = $urandom_range(0, 7);
                ins = k < 6 ? r_ins(rs, rt, rd, fns[k]) : i_ins(iops[k-6], rs, rt, 16'($urandom));
                mem[i] = ins;
                model_exec(ins);
            end
            for (int i = 1; i <= 7; i++) mem[nk + i - 1] = i_ins(6'h2B, 0, i, 16'(32'h200 + 4 * i));
            mem[nk + 7] = i_ins(6'h04, 0, 0, 16'hFFFF);
            reset = 1'b0;
            cycles(nk * (4 + w) + 7 * (4 + 2 * w));
            check("rnd_retired", retired, 32'(nk + 7));
            check("rnd_pc", pc_debug, 32'(4 * (nk + 7)));
            for (int i = 1; i <= 7; i++) expect_write("rnd_reg", 32'(32'h200 + 4 * i), rm[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
- Multi-cycle successor to the single-cycle MIPS_CPU.
- One shared instruction/data memory port with a valid/ready handshake, so the core tolerates wait-state memories.
- An FSM sequences FETCH/DECODE/EXEC/MEM/WB and reuses RegisterFile, ALU and ImmExt.
- Adds reset-vector, crypt-key and counter parametrisation, a retired-instruction counter, and a sticky fault/halt state.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CRYPT_KEY, 32'hDEADB3EF, XOR key applied by the xcrypt instruction.
- RETIRE_W, 32, width of the retired-instruction counter (1..32).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write (sw), 0 = read.
- mem_addr  out  32  byte address, always word aligned.
- mem_wdata  out  32  store data (rt).
- mem_ready  in  1  transaction completes on the cycle mem_req & mem_ready.
- mem_rdata  in  32  read data, valid when mem_ready=1.
- halted  out  1  sticky; core stopped.
- fault  out  2  00 none, 01 illegal opcode/funct, 10 misaligned lw/sw.
- retired  out  RETIRE_W  count of completed instructions, wraps modulo 2^RETIRE_W.
- pc_debug  out  32  current PC.
- instruction_debug  out  32  instruction register.
- state_debug  out  3  FSM state code.

Behaviour:
- Reset (clk edge with reset=1), from any state including mid-transaction:
  - PC=RESET_PC, IR=0, state=FETCH, retired=0, halted=0, fault=00.
  - Register file cleared via its rst input.
  - mem_req forced 0 while reset=1.
- Registered outputs; mem_* are decoded from state and holding registers.
- State codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=PC.
  - Hold until mem_ready. On the ready cycle: IR<=mem_rdata, PC<=PC+4, then go to DECODE.
  - mem_addr/mem_we/mem_wdata stay stable while mem_req=1 and mem_ready=0.
- DECODE:
  - Latch A=rs, B=rt and the extended immediate.
  - Unsupported opcode or funct: fault=01, go to HALT.
  - Otherwise go to EXEC.
- Supported instructions:
  - R-type funct: add 20, sub 22, and 24, or 25, slt 2A, xcrypt 3F.
  - I-type: addi 08 (sign-extended), andi 0C and ori 0D (zero-extended), lw 23, sw 2B, beq 04.
  - J-type: j 02, jal 03.
- EXEC:
  - ALU result latched into ALUOut.
  - beq: if A==B, PC<=PC+(sext(imm)<<2), where PC already holds PC+4. Retire, go to FETCH.
  - j/jal: PC<={PC[31:28],IR[25:0],2'b00}. jal also writes $31 = old PC+4 (the PC value before the jump). Retire, go to FETCH.
  - lw/sw: if ALUOut[1:0]!=0, fault=10 and go to HALT. Otherwise go to MEM.
  - All others go to WB.
- MEM:
  - mem_req=1, mem_addr=ALUOut; mem_we=1 and mem_wdata=B for sw.
  - Hold until mem_ready.
  - sw: retire, go to FETCH.
  - lw: latch MDR<=mem_rdata, go to WB.
- WB writes one register, retires, and goes to FETCH:
  - R-type: rd <= ALUOut; xcrypt writes rd <= (rs+rt) ^ CRYPT_KEY.
  - I-type ALU ops: rt <= ALUOut.
  - lw: rt <= MDR.
- Writes to $0 are discarded.
- Retire means retired<=retired+1 in the completing cycle.
- Cycles per instruction with zero-wait memory (mem_ready tied 1):
  - beq/j/jal = 3.
  - R/I ALU and sw = 4.
  - lw = 5.
  - Each memory wait cycle adds 1.
- HALT: mem_req=0, halted=1. No state changes until reset. fault holds the first cause.
- A mem_ready pulse while mem_req=0 is ignored.

Test Plan:
- Zero-wait memory; program `addi $1,$0,5`; `addi $2,$0,-3`; `add $3,$1,$2` -> $3=2; retired=3 after 12 cycles post-reset; PC=12.
- mem_ready delayed 3 cycles on every request; `lw $4,8($0)` with mem[8]=0xCAFEF00D -> $4=0xCAFEF00D after 11 cycles; mem_addr stable while waiting.
- `sw $1,16($0)` ($1=5) -> exactly one cycle with mem_req=1, mem_we=1, mem_addr=16, mem_wdata=5.
- `xcrypt $5,$1,$2` with $1=1, $2=0 -> $5=0xDEADB3EE; `beq $0,$0,-1` -> PC returns to the beq address, retired increments each loop.
- `jal` to word 0x40 at PC=8 -> PC=0x100, $31=12. Then opcode 0x3F -> halted=1, fault=01, mem_req stays 0. Then `lw $1,2($0)` after reset -> fault=10.
- Assert reset during a FETCH wait state -> next cycle PC=RESET_PC, mem_req=0 while reset=1, retired=0; normal fetch resumes after release.
